cache_mem_arbiter: RTL and testbench

Arbitrates the single unified main memory between the I-cache miss handler (IF stage) and the D-cache miss/write-through handler (MEM stage) of the 16-bit five-stage pipelined CPU. Grants one requester at a time and sequences a full block fill as pipelined word reads. It steers returned words back to the owning cache and pulses a per-requester done. It also issues single-word write-through stores. It sits between the two cache controllers and the memory model, and its busy/done outputs drive the pipeline stall logic.

---
 rtl/cache_mem_arbiter.sv | 143 ++++++++++++++
 tb/tb_cache_mem_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_arbiter.sv
// Shares the unified main memory between the I-cache and D-cache miss handlers:
// D before I, block fills issued as back-to-back word reads, single-word write-through stores.
module cache_mem_arbiter #(
  parameter int ADDR_W          = 16,
  parameter int DATA_W          = 16,
  parameter int WORDS_PER_BLOCK = 8,
  parameter int MEM_LATENCY     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              d_req,
  input  logic              d_wr_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  output logic              fill_we,
  output logic              fill_sel,
  output logic [ADDR_W-1:0] fill_addr,
  output logic [DATA_W-1:0] fill_data,
  output logic              i_done,
  output logic              d_done,
  output logic              busy
);

  localparam int OW = $clog2(WORDS_PER_BLOCK);
  localparam int CW = OW + 1;
  localparam logic [CW-1:0] WPB_C  = CW'(WORDS_PER_BLOCK);
  localparam logic [CW-1:0] LAST_C = CW'(WORDS_PER_BLOCK - 1);

  typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

  state_t              state, state_nxt;
  logic                owner, owner_nxt;
  logic [ADDR_W-2:0]   addr_q, addr_nxt;
  logic [DATA_W-1:0]   wdata_q, wdata_nxt;
  logic [CW-1:0]       ic, ic_nxt;
  logic [CW-1:0]       rc, rc_nxt;

  // Byte bit 0 never matters: the memory is word-addressed.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_addr[0], d_addr[0]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      owner   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ic      <= '0;
      rc      <= '0;
    end else begin
      state   <= state_nxt;
      owner   <= owner_nxt;
      addr_q  <= addr_nxt;
      wdata_q <= wdata_nxt;
      ic      <= ic_nxt;
      rc      <= rc_nxt;
    end
  end

  // Memory and fill outputs depend only on registered state/counters, never on a req input.
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    addr_nxt  = addr_q;
    wdata_nxt = wdata_q;
    ic_nxt    = ic;
    rc_nxt    = rc;
    mem_en    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    fill_we   = 1'b0;
    fill_sel  = 1'b0;
    fill_addr = '0;
    fill_data = '0;
    i_done    = 1'b0;
    d_done    = 1'b0;

    case (state)
      IDLE: begin
        if (d_wr_req) begin
          owner_nxt = 1'b1;
          addr_nxt  = d_addr[ADDR_W-1:1];
          wdata_nxt = d_wdata;
          state_nxt = WRITE;
        end else if (d_req) begin
          owner_nxt = 1'b1;
          addr_nxt  = d_addr[ADDR_W-1:1];
          state_nxt = FILL;
        end else if (i_req) begin
          owner_nxt = 1'b0;
          addr_nxt  = i_addr[ADDR_W-1:1];
          state_nxt = FILL;
        end
      end

      FILL: begin
        if (ic < WPB_C) begin
          mem_en   = 1'b1;
          mem_addr = {addr_q[ADDR_W-2:OW], ic[OW-1:0], 1'b0};
          ic_nxt   = ic + CW'(1);
        end
        if (mem_rvalid) begin
          fill_we   = 1'b1;
          fill_sel  = owner;
          fill_addr = {addr_q[ADDR_W-2:OW], rc[OW-1:0], 1'b0};
          fill_data = mem_rdata;
          rc_nxt    = rc + CW'(1);
          if (rc == LAST_C) state_nxt = DONE;
        end
      end

      WRITE: begin
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = {addr_q, 1'b0};
        mem_wdata = wdata_q;
        state_nxt = DONE;
      end

      DONE: begin
        i_done    = ~owner;
        d_done    = owner;
        ic_nxt    = '0;
        rc_nxt    = '0;
        state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: a latency-accurate memory model plus
// per-cycle scoreboards for memory accesses, cache fills, done pulses and busy.
module tb_cache_mem_arbiter;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int W  = 8;
  localparam int L  = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_req, d_req, d_wr_req;
  logic [AW-1:0] i_addr, d_addr;
  logic [DW-1:0] d_wdata;
  logic          mem_en, mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_rvalid;
  logic          fill_we, fill_sel;
  logic [AW-1:0] fill_addr;
  logic [DW-1:0] fill_data;
  logic          i_done, d_done, busy;

  cache_mem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .WORDS_PER_BLOCK(W), .MEM_LATENCY(L)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr),
    .d_req(d_req), .d_wr_req(d_wr_req), .d_addr(d_addr), .d_wdata(d_wdata),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .fill_we(fill_we), .fill_sel(fill_sel), .fill_addr(fill_addr), .fill_data(fill_data),
    .i_done(i_done), .d_done(d_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] memData(input logic [AW-1:0] a);
    return {a[7:0], a[15:8]} ^ 16'h3C5A;
  endfunction

  // Memory model: a read issued in cycle c returns in cycle c+L
  logic [L-1:0]  pv = '0;
  logic [DW-1:0] pd [L];
  logic          stray_rvalid = 1'b0;
  always @(posedge clk) begin
    pv <= {pv[L-2:0], mem_en & ~mem_wr};
    pd[0] <= memData(mem_addr);
    for (int i = 1; i < L; i++) pd[i] <= pd[i-1];
  end
  assign mem_rvalid = pv[L-1] | stray_rvalid;
  assign mem_rdata  = pv[L-1] ? pd[L-1] : 16'hDEAD;

  int vec_count   = 0;
  int miscompares = 0;
  int last_done   = 0;
  bit mon_en      = 1'b0;

  typedef struct {
    int            cyc;
    logic          sel;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ev_t;

  typedef struct {
    int from;
    int to;
  } span_t;

  ev_t   mem_q[$];
  ev_t   fill_q[$];
  ev_t   done_q[$];
  span_t busy_q[$];

  task automatic checkOutput(input string name, input logic [79:0] act, input logic [79:0] exp);
    vec_count++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [79:0] allOutputs();
    return 80'({mem_en, mem_wr, mem_addr, mem_wdata, fill_we, fill_sel, fill_addr,
                fill_data, i_done, d_done, busy});
  endfunction

  task automatic pushFill(input int t, input logic sel, input logic [AW-1:0] base);
    for (int k = 0; k < W; k++) begin
      logic [AW-1:0] a;
      a = AW'(base + AW'(2 * k));
      mem_q.push_back('{t + 1 + k, 1'b0, a, '0});
      fill_q.push_back('{t + 1 + k + L, sel, a, memData(a)});
    end
    done_q.push_back('{t + 1 + W + L, sel, '0, '0});
    busy_q.push_back('{t + 1, t + 1 + W + L});
  endtask

  task automatic pushWrite(input int t, input logic [AW-1:0] a, input logic [DW-1:0] d);
    mem_q.push_back('{t + 1, 1'b1, a, d});
    done_q.push_back('{t + 2, 1'b1, '0, '0});
    busy_q.push_back('{t + 1, t + 2});
  endtask

  // Per-cycle monitor: every observed event must match the head of its queue in that exact cycle
  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      logic exp_busy;
      if (mem_en) begin
        if (mem_q.size() > 0 && mem_q[0].cyc == cyc) begin
          checkOutput("mem_wr", 80'(mem_wr), 80'(mem_q[0].sel));
          checkOutput("mem_addr", 80'(mem_addr), 80'(mem_q[0].addr));
          if (mem_q[0].sel) checkOutput("mem_wdata", 80'(mem_wdata), 80'(mem_q[0].data));
          void'(mem_q.pop_front());
        end else checkOutput("mem_unexpected", 80'(mem_en), 80'(0));
      end else if (mem_q.size() > 0 && mem_q[0].cyc <= cyc) begin
        checkOutput("mem_missing", 80'(mem_en), 80'(1));
        void'(mem_q.pop_front());
      end

      if (fill_we) begin
        if (fill_q.size() > 0 && fill_q[0].cyc == cyc) begin
          checkOutput("fill_sel", 80'(fill_sel), 80'(fill_q[0].sel));
          checkOutput("fill_addr", 80'(fill_addr), 80'(fill_q[0].addr));
          checkOutput("fill_data", 80'(fill_data), 80'(fill_q[0].data));
          void'(fill_q.pop_front());
        end else checkOutput("fill_unexpected", 80'(fill_we), 80'(0));
      end else if (fill_q.size() > 0 && fill_q[0].cyc <= cyc) begin
        checkOutput("fill_missing", 80'(fill_we), 80'(1));
        void'(fill_q.pop_front());
      end

      if (i_done || d_done) begin
        if (done_q.size() > 0 && done_q[0].cyc == cyc) begin
          checkOutput("done_pulse", 80'({i_done, d_done}),
                      80'({~done_q[0].sel, done_q[0].sel}));
          void'(done_q.pop_front());
        end else checkOutput("done_unexpected", 80'({i_done, d_done}), 80'(0));
      end else if (done_q.size() > 0 && done_q[0].cyc <= cyc) begin
        checkOutput("done_missing", 80'({i_done, d_done}), 80'({~done_q[0].sel, done_q[0].sel}));
        void'(done_q.pop_front());
      end

      while (busy_q.size() > 0 && busy_q[0].to < cyc) void'(busy_q.pop_front());
      exp_busy = (busy_q.size() > 0 && cyc >= busy_q[0].from && cyc <= busy_q[0].to);
      checkOutput("busy", 80'(busy), 80'(exp_busy));
    end
  end

  // Holds requests until one negedge after their done pulse, the latest legal drop
  task automatic serviceRequests(input int budget);
    int n = 0;
    bit drop_i = 1'b0;
    bit drop_d = 1'b0;
    while ((i_req || d_req || d_wr_req) && n < budget) begin
      @(negedge clk);
      n++;
      if (drop_i) begin i_req = 1'b0; drop_i = 1'b0; end
      if (drop_d) begin d_req = 1'b0; d_wr_req = 1'b0; drop_d = 1'b0; end
      if (i_done) begin drop_i = 1'b1; last_done = cyc; end
      if (d_done) begin drop_d = 1'b1; last_done = cyc; end
    end
    checkOutput("service_timeout", 80'({i_req, d_req, d_wr_req}), 80'(0));
    i_req = 1'b0; d_req = 1'b0; d_wr_req = 1'b0;
  endtask

  typedef struct {
    logic          ir, dr, dw;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [AW-1:0] exp_addr;
    int            exp_lat;
  } vec_t;

  vec_t vecs[8];

  task automatic applyStimulus(input vec_t v);
    int t;
    t = cyc;
    i_req    = v.ir;
    d_req    = v.dr;
    d_wr_req = v.dw;
    i_addr   = v.ir ? v.addr : AW'($urandom);
    d_addr   = v.ir ? AW'($urandom) : v.addr;
    d_wdata  = v.wdata;
    if (v.dw) pushWrite(t, v.exp_addr, v.wdata);
    else      pushFill(t, ~v.ir, v.exp_addr);
    serviceRequests(100);
    checkOutput("done_latency", 80'(last_done - t), 80'(v.exp_lat));
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t;
    vecs[0] = '{1'b1, 1'b0, 1'b0, 16'h0036, 16'h0000, 16'h0030, 13};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 16'h0207, 16'h0000, 16'h0200, 13};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 16'h1235, 16'hBEEF, 16'h1234, 2};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 16'hFFFF, 16'h0000, 16'hFFF0, 13};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 16'h7FF1, 16'h0000, 16'h7FF0, 13};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 16'h0000, 16'h1234, 16'h0000, 2};
    vecs[6] = '{1'b0, 1'b0, 1'b1, 16'hFFFF, 16'hA5A5, 16'hFFFE, 2};
    vecs[7] = '{1'b0, 1'b1, 1'b1, 16'h0042, 16'h5555, 16'h0042, 2};

    rst_n = 1'b0; i_req = 1'b0; d_req = 1'b0; d_wr_req = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_outputs", allOutputs(), 80'(0));
    rst_n = 1'b1;
    mon_en = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);

    $display("[TB] simultaneous I and D read misses");
    t = cyc;
    i_req = 1'b1; i_addr = 16'h0100;
    d_req = 1'b1; d_addr = 16'h0200;
    pushFill(t, 1'b1, 16'h0200);
    pushFill(t + 14, 1'b0, 16'h0100);
    serviceRequests(100);
    checkOutput("i_after_d_latency", 80'(last_done - t), 80'(27));
    repeat (2) @(negedge clk);

    $display("[TB] back-to-back store then pending I miss");
    t = cyc;
    d_wr_req = 1'b1; d_addr = 16'h0ABC; d_wdata = 16'h1111;
    i_req = 1'b1; i_addr = 16'h0500;
    pushWrite(t, 16'h0ABC, 16'h1111);
    pushFill(t + 3, 1'b0, 16'h0500);
    serviceRequests(100);
    checkOutput("b2b_i_latency", 80'(last_done - t), 80'(16));
    repeat (2) @(negedge clk);

    $display("[TB] stray rvalid in IDLE and WRITE");
    stray_rvalid = 1'b1;
    #1;
    checkOutput("stray_idle_fill_we", 80'(fill_we), 80'(0));
    @(negedge clk);
    stray_rvalid = 1'b0;
    checkOutput("stray_idle_busy", 80'(busy), 80'(0));
    t = cyc;
    d_wr_req = 1'b1; d_addr = 16'h2001; d_wdata = 16'h7777;
    pushWrite(t, 16'h2000, 16'h7777);
    @(negedge clk);
    stray_rvalid = 1'b1;
    #1;
    checkOutput("stray_write_fill_we", 80'(fill_we), 80'(0));
    @(negedge clk);
    stray_rvalid = 1'b0;
    checkOutput("stray_write_done", 80'({i_done, d_done}), 80'(1));
    d_wr_req = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] reset during a fill");
    t = cyc;
    i_req = 1'b1; i_addr = 16'h0100;
    for (int k = 0; k < 3; k++) mem_q.push_back('{t + 1 + k, 1'b0, AW'(16'h0100 + 2 * k), '0});
    busy_q.push_back('{t + 1, t + 3});
    repeat (3) @(negedge clk);
    rst_n = 1'b0; i_req = 1'b0;
    @(negedge clk);
    checkOutput("reset_midfill_outputs", allOutputs(), 80'(0));
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      checkOutput("late_rvalid_fill_we", 80'(fill_we), 80'(0));
      checkOutput("late_rvalid_done", 80'({i_done, d_done}), 80'(0));
    end

    repeat (3) @(negedge clk);
    checkOutput("leftover_mem", 80'(mem_q.size()), 80'(0));
    checkOutput("leftover_fill", 80'(fill_q.size()), 80'(0));
    checkOutput("leftover_done", 80'(done_q.size()), 80'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
